// File: rtl/uart_frame_parser.sv
// Command-frame parser for the UART byte stream: checks sync, length and additive checksum,
// then holds each good frame and its payload until the consumer acknowledges it.
module uart_frame_parser #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 50000,
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int unsigned TW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    in_dat,
  input  logic          in_ok,
  output logic          frame_valid,
  input  logic          frame_ack,
  output logic [7:0]    cmd,
  output logic [7:0]    len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          frame_err,
  output logic [1:0]    err_code
);

  typedef enum logic [2:0] {StIdle, StSync1, StCmd, StLen, StData, StChk} state_e;

  state_e        state;
  logic [7:0]    cmd_cur;
  logic [7:0]    len_cur;
  logic [7:0]    sum;
  logic [AW:0]   cnt;
  logic          ovr;
  logic [TW-1:0] to_cnt;
  logic [7:0]    mem [MAX_LEN];

  logic          wr_en;
  logic [AW:0]   cnt_nxt;
  logic          last_byte;
  logic          to_hit;

  // A held payload is never overwritten: overrun frames only feed the checksum.
  assign wr_en     = in_ok && (state == StData) && !ovr;
  assign cnt_nxt   = cnt + 1'b1;
  assign last_byte = (32'(cnt_nxt) == 32'(len_cur));
  assign to_hit    = (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= StIdle;
      cmd_cur     <= 8'h00;
      len_cur     <= 8'h00;
      sum         <= 8'h00;
      cnt         <= '0;
      ovr         <= 1'b0;
      to_cnt      <= '0;
      frame_valid <= 1'b0;
      cmd         <= 8'h00;
      len         <= 8'h00;
      frame_err   <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      frame_err <= 1'b0;
      if (frame_valid && frame_ack) begin
        frame_valid <= 1'b0;
      end
      if (in_ok) begin
        to_cnt <= '0;
        unique case (state)
          StIdle: begin
            if (in_dat == 8'hA5) begin
              state <= StSync1;
            end
          end
          StSync1: begin
            if (in_dat == 8'h5A) begin
              state <= StCmd;
            end else if (in_dat != 8'hA5) begin
              state <= StIdle;
            end
          end
          StCmd: begin
            cmd_cur <= in_dat;
            sum     <= in_dat;
            ovr     <= frame_valid;
            state   <= StLen;
          end
          StLen: begin
            len_cur <= in_dat;
            sum     <= sum + in_dat;
            if (32'(in_dat) > MAX_LEN) begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
              state     <= StIdle;
            end else if (in_dat == 8'h00) begin
              state <= StChk;
            end else begin
              cnt   <= '0;
              state <= StData;
            end
          end
          StData: begin
            sum <= sum + in_dat;
            cnt <= cnt_nxt;
            if (last_byte) begin
              state <= StChk;
            end
          end
          StChk: begin
            if (in_dat != sum) begin
              frame_err <= 1'b1;
              err_code  <= 2'd1;
            end else if (ovr) begin
              frame_err <= 1'b1;
              err_code  <= 2'd0;
            end else begin
              cmd         <= cmd_cur;
              len         <= len_cur;
              frame_valid <= 1'b1;
            end
            state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end else if (state == StIdle) begin
        to_cnt <= '0;
      end else if (to_hit) begin
        to_cnt    <= '0;
        frame_err <= 1'b1;
        err_code  <= 2'd3;
        state     <= StIdle;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[cnt[AW-1:0]] <= in_dat;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= 8'h00;
    end else if (32'(rd_addr) < MAX_LEN) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= 8'h00;
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized bench for uart_frame_parser: frames are built from the format rules and the
// expected outcome of each is predicted from a transaction-level model of the held frame.
module tb_uart_frame_parser;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] in_dat = 8'h00;
  logic       in_ok = 1'b0;
  logic       frame_ack = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic       frame_valid;
  logic [7:0] cmd;
  logic [7:0] len;
  logic [7:0] rd_data;
  logic       frame_err;
  logic [1:0] err_code;

  int n_vec = 0;
  int n_err = 0;
  int pulses_seen = 0;
  int pulses_exp = 0;

  logic [7:0] fq[$];
  bit         m_valid = 1'b0;
  logic [7:0] m_cmd;
  logic [7:0] m_len;
  logic [7:0] m_buf [MAX_LEN];

  uart_frame_parser #(
    .MAX_LEN(MAX_LEN),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_dat     (in_dat),
    .in_ok      (in_ok),
    .frame_valid(frame_valid),
    .frame_ack  (frame_ack),
    .cmd        (cmd),
    .len        (len),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_err  (frame_err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) pulses_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives fq; gap < 0 gives random 0..3 idle clocks between bytes.
  task automatic send_q(input int ack_idx, input int gap);
    for (int i = 0; i < fq.size(); i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
      if (i > 0 && g > 0) begin
        in_ok = 1'b0;
        frame_ack = 1'b0;
        repeat (g) @(negedge clk);
      end
      in_ok = 1'b1;
      in_dat = fq[i];
      frame_ack = (i == ack_idx);
      @(negedge clk);
    end
    in_ok = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic check_payload();
    for (int i = 0; i < int'(m_len); i++) begin
      rd_addr = 4'(i);
      @(negedge clk);
      check($sformatf("rd_data[%0d]", i), rd_data, m_buf[i]);
    end
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    m_valid = 1'b0;
    check("ack_clears_valid", frame_valid, 0);
  endtask

  // kind: 0 good checksum, 1 corrupted checksum. l > MAX_LEN stops the frame after LEN.
  task automatic run_frame(input logic [7:0] c, input int l, input int kind, input int junk,
                           input bit resync, input bit ack_mid, input int gap, input bit seq);
    logic [7:0] pay[$];
    logic [7:0] chk;
    int         s;
    int         exp_code;
    int         ack_idx;
    fq.delete();
    for (int i = 0; i < junk; i++) begin
      logic [7:0] b;
      do b = 8'($urandom); while (b == 8'hA5);
      fq.push_back(b);
    end
    if (junk > 0 && $urandom_range(1, 0) == 1) begin
      logic [7:0] b;
      do b = 8'($urandom); while (b == 8'hA5 || b == 8'h5A);
      fq.push_back(8'hA5);
      fq.push_back(b);
    end
    if (resync) fq.push_back(8'hA5);
    fq.push_back(8'hA5);
    fq.push_back(8'h5A);
    fq.push_back(c);
    fq.push_back(8'(l));
    ack_idx = ack_mid ? fq.size() - 1 : -1;
    if (l <= int'(MAX_LEN)) begin
      s = int'(c) + l;
      for (int i = 0; i < l; i++) begin
        pay.push_back(seq ? 8'(i + 1) : 8'($urandom));
        s += int'(pay[i]);
      end
      chk = 8'(s % 256);
      if (kind == 1) chk = chk ^ 8'($urandom_range(255, 1));
      foreach (pay[i]) fq.push_back(pay[i]);
      fq.push_back(chk);
    end
    if (l > int'(MAX_LEN)) exp_code = 2;
    else if (kind == 1) exp_code = 1;
    else if (m_valid) exp_code = 0;
    else exp_code = -1;
    if (ack_mid) m_valid = 1'b0;
    if (exp_code < 0) begin
      m_valid = 1'b1;
      m_cmd = c;
      m_len = 8'(l);
      for (int i = 0; i < l; i++) m_buf[i] = pay[i];
    end
    send_q(ack_idx, gap);
    check("frame_err", frame_err, exp_code >= 0);
    if (exp_code >= 0) begin
      pulses_exp++;
      check("err_code", err_code, exp_code);
    end
    check("frame_valid", frame_valid, m_valid);
    if (m_valid) begin
      check("cmd", cmd, m_cmd);
      check("len", len, m_len);
      check_payload();
    end
  endtask

  task automatic run_timeout(input int nbytes);
    int         first;
    logic [1:0] code_at;
    first = -1;
    code_at = 2'd0;
    fq.delete();
    fq.push_back(8'hA5);
    if (nbytes > 1) fq.push_back(8'h5A);
    if (nbytes > 2) fq.push_back(8'h10);
    send_q(-1, 0);
    for (int k = 1; k <= int'(TIMEOUT) + 4; k++) begin
      @(negedge clk);
      if (frame_err && first < 0) begin
        first = k;
        code_at = err_code;
      end
    end
    pulses_exp++;
    check($sformatf("timeout_cycle_%0d", nbytes), first, TIMEOUT);
    check($sformatf("timeout_code_%0d", nbytes), code_at, 3);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_cmd", cmd, 0);
    check("rst_len", len, 0);
    check("rst_rd_data", rd_data, 0);
    rstn = 1'b1;
    @(negedge clk);

    run_frame(8'h10, 3, 0, 0, 0, 0, 0, 1);
    do_ack();
    run_frame(8'h10, 1, 1, 0, 0, 0, 0, 0);
    run_frame(8'h21, 4, 0, 2, 0, 0, -1, 0);
    do_ack();
    run_frame(8'h20, 17, 0, 0, 0, 0, 0, 0);
    run_frame(8'h01, 0, 0, 0, 1, 0, 0, 0);
    do_ack();
    run_timeout(3);
    run_timeout(1);
    run_frame(8'h42, 2, 0, 0, 0, 0, int'(TIMEOUT) - 2, 0);
    run_frame(8'h55, 5, 0, 0, 0, 0, 0, 0);
    run_frame(8'h56, 3, 0, 0, 0, 1, 0, 0);
    run_frame(8'h57, MAX_LEN, 0, 0, 0, 0, 0, 0);

    // Abandon a frame mid-payload with an asynchronous reset.
    fq.delete();
    fq = '{8'hA5, 8'h5A, 8'h22, 8'h08, 8'h11, 8'h22};
    send_q(-1, 0);
    #2 rstn = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    check("midrst_frame_valid", frame_valid, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_err_code", err_code, 0);
    check("midrst_cmd", cmd, 0);
    check("midrst_len", len, 0);
    check("midrst_rd_data", rd_data, 0);
    rstn = 1'b1;
    @(negedge clk);
    run_frame(8'h33, 6, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int sel;
      int l;
      sel = int'($urandom_range(9, 0));
      if (m_valid && $urandom_range(1, 0) == 1) do_ack();
      l = (sel >= 8) ? int'($urandom_range(255, MAX_LEN + 1)) : int'($urandom_range(MAX_LEN, 0));
      run_frame(8'($urandom), l, (sel == 6 || sel == 7) ? 1 : 0, int'($urandom_range(3, 0)),
                1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0),
                ($urandom_range(1, 0) == 0) ? -1 : 0, 0);
    end

    repeat (3) @(negedge clk);
    check("err_pulse_count", pulses_seen, pulses_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
